// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers,
// with per-requester message locking and a transmitter start timeout.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_byte,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_byte,
    output logic               transmit,
    input  logic               is_transmitting,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               timeout_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_INIT = IW'(N_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_HOLD       = 3'd4
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t             state_r, state_s;
    logic [IW-1:0]      ptr_r;
    logic [IW-1:0]      owner_r, owner_s;
    logic               lock_r, lock_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [7:0]         tx_byte_r;
    logic               transmit_r;
    logic [N_REQ-1:0]   grant_r;
    logic               busy_r;

    logic               win_found_s;
    logic [IW-1:0]      win_idx_s;
    logic [IW-1:0]      cand_s;
    logic [N_REQ-1:0]   ready_s;
    logic               accept_s;
    logic [IW-1:0]      sel_s;
    logic               timeout_s;

    // Round-robin search starting just after the last served requester
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IW{1'b0}};
        cand_s      = {IW{1'b0}};
        for (int j = 1; j <= N_REQ; j++) begin
            cand_s = IW'((int'(ptr_r) + j) % N_REQ);
            if (!win_found_s && req_valid[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state, accept strobe and timeout decision
    always_comb begin
        state_s   = state_r;
        ready_s   = {N_REQ{1'b0}};
        accept_s  = 1'b0;
        sel_s     = owner_r;
        cnt_s     = cnt_r;
        lock_s    = lock_r;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    ready_s[win_idx_s] = 1'b1;
                    accept_s           = 1'b1;
                    sel_s              = win_idx_s;
                    state_s            = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_s   = {CW{1'b0}};
                state_s = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                // A start seen on the terminal-count cycle still wins over the timeout
                if (is_transmitting) begin
                    state_s = ST_WAIT_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s = 1'b1;
                    lock_s    = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CW'(1'b1);
                end
            end
            ST_WAIT_DONE: begin
                if (!is_transmitting) begin
                    state_s = lock_r ? ST_HOLD : ST_IDLE;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            ST_HOLD: begin
                if (req_valid[owner_r]) begin
                    ready_s[owner_r] = 1'b1;
                    accept_s         = 1'b1;
                    state_s          = ST_START;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                lock_s  = 1'b0;
            end
        endcase
        if (accept_s) begin
            lock_s = ~req_last[sel_s];
        end else begin
            lock_s = lock_s;
        end
        owner_s = accept_s ? sel_s : owner_r;
    end

    // Sequencing state, latched byte and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PTR_INIT;
            owner_r    <= {IW{1'b0}};
            lock_r     <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            tx_byte_r  <= 8'h00;
            transmit_r <= 1'b0;
            grant_r    <= {N_REQ{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            lock_r  <= lock_s;
            owner_r <= owner_s;
            if (accept_s) begin
                tx_byte_r <= req_byte[{sel_s, 3'b000} +: 8];
                if (state_r == ST_IDLE) begin
                    ptr_r <= sel_s;
                end
            end
            transmit_r <= (state_s == ST_START);
            busy_r     <= (state_s != ST_IDLE);
            grant_r    <= (state_s != ST_IDLE) ? onehot(owner_s) : {N_REQ{1'b0}};
        end
    end

    assign req_ready   = rst ? ready_s : {N_REQ{1'b0}};
    assign tx_byte     = tx_byte_r;
    assign transmit    = transmit_r;
    assign grant       = grant_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_s;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a behavioural UART and a
// timestamp-based reference model compared against the DUT every cycle.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_byte;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_byte;
    logic           transmit;
    logic           is_transmitting;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_err;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_byte(req_byte),
        .req_last(req_last), .req_ready(req_ready), .tx_byte(tx_byte),
        .transmit(transmit), .is_transmitting(is_transmitting), .grant(grant),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef logic [8:0] item_q_t [$];
    item_q_t rq [N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural UART
    int u_delay = 1, u_len = 8, u_start = 0, u_left = 0, u_frames = 0;
    bit u_dead = 1'b0;
    logic tx_seen = 1'b0;
    logic [N-1:0] hs_seen = '0;

    // observation logs
    int log_q [$];
    int to_gaps [$];
    int acc_gaps [$];
    int n_to = 0, tx_cyc = 0, fall_cyc = -100;
    logic prev_istx = 1'b0;

    // reference model state: owner (-1 free), cycle of last accept, phase flags
    int m_owner, m_ptr, m_acc;
    logic [7:0] m_byte;
    bit m_locked, m_started, m_hold;
    logic [N-1:0] er, e_grant, hs_m;
    bit e_tx, e_to, waiting;
    int hidx;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = N - 1; m_acc = -100; m_byte = 8'h00;
        m_locked = 1'b0; m_started = 1'b0; m_hold = 1'b0;
    endtask

    task automatic apply();
        logic [8:0] it;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                it = rq[i][0];
                req_valid[i] = 1'b1;
                req_byte[8*i +: 8] = it[7:0];
                req_last[i] = it[8];
            end else begin
                req_valid[i] = 1'b0;
                req_byte[8*i +: 8] = 8'h00;
                req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        rq[r].push_back({l, b});
        apply();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic int logv(input int i);
        return (i < log_q.size()) ? log_q[i] : -1;
    endfunction

    // requester pops, input refresh and UART behaviour, just after each edge
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++)
            if (hs_seen[i] && rq[i].size() > 0) rq[i].delete(0);
        apply();
        if (!rst) begin
            u_start = 0; u_left = 0; is_transmitting = 1'b0;
        end else begin
            if (tx_seen && !u_dead) u_start = u_delay;
            if (u_start > 0) begin
                u_start--;
                if (u_start == 0) begin
                    is_transmitting = 1'b1; u_left = u_len; u_frames++;
                end
            end else if (u_left > 0) begin
                u_left--;
                if (u_left == 0) is_transmitting = 1'b0;
            end
        end
    end

    // compare DUT with model on the falling edge, then advance the model
    always @(negedge clk) begin
        if (!rst) model_reset();
        er = '0;
        if (rst && m_owner < 0) begin
            for (int j = 1; j <= N; j++)
                if (er == '0 && req_valid[(m_ptr + j) % N]) er[(m_ptr + j) % N] = 1'b1;
        end else if (rst && m_hold) begin
            er[m_owner] = req_valid[m_owner];
        end
        e_tx = rst && m_owner >= 0 && !m_hold && (cyc == m_acc + 1);
        waiting = rst && m_owner >= 0 && !m_hold && !m_started && (cyc > m_acc + 1);
        e_to = waiting && !is_transmitting && ((cyc - (m_acc + 1)) == TO);
        e_grant = '0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("transmit", transmit, e_tx);
        chk("tx_byte", tx_byte, m_byte);
        chk("grant", grant, e_grant);
        chk("busy", busy, m_owner >= 0);
        chk("timeout_err", timeout_err, e_to);

        hs_seen = req_valid & req_ready;
        tx_seen = transmit;
        if (transmit) begin
            hidx = 0;
            for (int i = 0; i < N; i++) if (grant[i]) hidx = i;
            log_q.push_back(hidx * 256 + int'(tx_byte));
            tx_cyc = cyc;
        end
        if (timeout_err) begin n_to++; to_gaps.push_back(cyc - tx_cyc); end
        if (hs_seen != '0) acc_gaps.push_back(cyc - fall_cyc);
        if (prev_istx && !is_transmitting) fall_cyc = cyc;
        prev_istx = is_transmitting;

        if (rst) begin
            hs_m = req_valid & er;
            if (hs_m != '0) begin
                hidx = 0;
                for (int i = 0; i < N; i++) if (hs_m[i]) hidx = i;
                m_byte = req_byte[8*hidx +: 8];
                if (m_owner < 0) m_ptr = hidx;
                m_owner = hidx; m_locked = !req_last[hidx];
                m_acc = cyc; m_started = 1'b0; m_hold = 1'b0;
            end else if (waiting) begin
                if (is_transmitting) m_started = 1'b1;
                else if (e_to) begin m_owner = -1; m_locked = 1'b0; end
            end else if (m_owner >= 0 && m_started && !is_transmitting) begin
                m_started = 1'b0;
                if (m_locked) m_hold = 1'b1; else m_owner = -1;
            end
        end
    end

    task automatic wait_log(input int n, input int maxc);
        int k = 0;
        while (log_q.size() < n && k < maxc) begin @(posedge clk); k++; end
        #2;
        chk("wait_log", log_q.size() >= n, 1'b1);
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while ((busy || is_transmitting || rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() > 0)
               && k < maxc) begin @(posedge clk); k++; end
        #2;
        chk("wait_idle", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, f0, k;
        rst = 1'b0; is_transmitting = 1'b0;
        req_valid = '0; req_byte = '0; req_last = '0;
        model_reset();
        // reset values, ready held off even with a valid requester
        tick(3);
        push(0, 8'h5A, 1'b1);
        #1;
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_transmit", transmit, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        rq[0].delete(); apply();
        tick(1); rst = 1'b1; tick(2);

        // single request
        push(2, 8'hA5, 1'b1);
        #1 chk("single_ready", req_ready, 4'b0100);
        tick(1);
        chk("single_transmit", transmit, 1'b1);
        chk("single_tx_byte", tx_byte, 8'hA5);
        chk("single_grant", grant, 4'b0100);
        wait_idle(100);
        chk("single_log", logv(0), 32'h2A5);

        // contention from reset: serve order 0,1,2,3,0,1,2,3
        tick(1); rst = 1'b0; tick(2); rst = 1'b1; tick(1);
        log_q.delete(); f0 = u_frames;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 8'(32'h20 + i + 4 * r), 1'b1);
        #1 chk("contend_ready", req_ready, 4'b0001);
        wait_log(8, 400); wait_idle(100);
        chk("contend_0", logv(0), 32'h020);
        chk("contend_1", logv(1), 32'h121);
        chk("contend_2", logv(2), 32'h222);
        chk("contend_3", logv(3), 32'h323);
        chk("contend_4", logv(4), 32'h024);
        chk("contend_7", logv(7), 32'h327);
        chk("contend_frames", u_frames - f0, 8);

        // lock: both req 1 bytes before req 0
        log_q.delete();
        push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b1);
        tick(3); push(0, 8'h30, 1'b1);
        wait_log(3, 200); wait_idle(100);
        chk("lock_0", logv(0), 32'h110);
        chk("lock_1", logv(1), 32'h111);
        chk("lock_2", logv(2), 32'h030);

        // locked owner that does not revalidate keeps the transmitter
        log_q.delete();
        push(1, 8'h12, 1'b0);
        tick(20);
        chk("hold_busy", busy, 1'b1);
        chk("hold_grant", grant, 4'b0010);
        push(3, 8'h3C, 1'b1);
        #1 chk("hold_ready", req_ready, 4'b0000);
        tick(5);
        chk("hold_log_size", log_q.size(), 1);
        push(1, 8'h13, 1'b1);
        wait_log(3, 200); wait_idle(100);
        chk("hold_1", logv(1), 32'h113);
        chk("hold_2", logv(2), 32'h33C);

        // start timeout with a dead transmitter
        u_dead = 1'b1; log_q.delete(); to_gaps.delete(); n0 = n_to;
        push(2, 8'h44, 1'b0); push(3, 8'h55, 1'b1);
        k = 0;
        while (n_to - n0 < 2 && k < 200) begin @(posedge clk); k++; end
        #2;
        chk("to_count", n_to - n0, 2);
        chk("to_gap0", to_gaps.size() > 0 ? to_gaps[0] : -1, 16);
        chk("to_gap1", to_gaps.size() > 1 ? to_gaps[1] : -1, 16);
        chk("to_log0", logv(0), 32'h244);
        chk("to_log1", logv(1), 32'h355);
        u_dead = 1'b0;
        wait_idle(100);

        // start seen on the terminal-count cycle is a success
        u_delay = 16; n0 = n_to; log_q.delete();
        push(0, 8'h66, 1'b1);
        wait_log(1, 100); wait_idle(200);
        chk("tc_no_timeout", n_to - n0, 0);
        chk("tc_log", logv(0), 32'h066);
        u_delay = 1;

        // requester withdrawing before ready consumes nothing
        log_q.delete();
        push(0, 8'h70, 1'b1);
        tick(2); push(1, 8'h71, 1'b1);
        tick(2); rq[1].delete(); apply();
        wait_idle(100); tick(3);
        chk("drop_size", log_q.size(), 1);
        chk("drop_log", logv(0), 32'h070);

        // reset in the middle of a frame
        push(2, 8'h80, 1'b1);
        k = 0;
        while (!is_transmitting && k < 30) begin @(posedge clk); k++; end
        tick(2);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 4'b0000);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_tx_byte", tx_byte, 8'h00);
        chk("mid_rst_transmit", transmit, 1'b0);
        tick(2); rst = 1'b1; tick(1);
        log_q.delete();
        push(1, 8'h92, 1'b1); push(3, 8'h90, 1'b1);
        #1 chk("post_rst_ready", req_ready, 4'b0010);
        wait_log(2, 200); wait_idle(100);
        chk("post_rst_0", logv(0), 32'h192);
        chk("post_rst_1", logv(1), 32'h390);

        // back-to-back single requester
        u_len = 5; log_q.delete(); acc_gaps.delete();
        push(0, 8'hA0, 1'b1); push(0, 8'hA1, 1'b1); push(0, 8'hA2, 1'b1);
        wait_log(3, 200); wait_idle(100);
        chk("b2b_log2", logv(2), 32'h0A2);
        chk("b2b_gap1", acc_gaps.size() > 1 ? acc_gaps[1] : -1, 1);
        chk("b2b_gap2", acc_gaps.size() > 2 ? acc_gaps[2] : -1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart` transmitter among `N_REQ` byte-producing requesters. Each requester offers a byte with a valid/ready handshake. The arbiter latches the winning byte, pulses `transmit`, and tracks the UART's `is_transmitting` until the frame completes. Requesters can lock the transmitter for multi-byte messages. A start timeout covers a transmitter that never responds. It sits between client logic and the `tx_byte`/`transmit`/`is_transmitting` pins of a `uart` instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `TIMEOUT`, 16, cycles allowed from `transmit` pulse to `is_transmitting` rising (>=2).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N_REQ  requester i offers a byte.
- `req_byte`  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
- `req_last`  in  N_REQ  offered byte ends the message; 0 = keep the lock.
- `req_ready`  out  N_REQ  one-hot accept strobe; a handshake occurs when valid and ready are both high.
- `tx_byte`  out  8  registered byte to `uart.tx_byte`.
- `transmit`  out  1  one-cycle start pulse to `uart.transmit`.
- `is_transmitting`  in  1  from `uart.is_transmitting`.
- `grant`  out  N_REQ  one-hot owner of the transmitter; 0 when free.
- `busy`  out  1  state != IDLE.
- `timeout_err`  out  1  one-cycle pulse on start timeout.

## Operation
- Registers:
  - `state`.
  - `ptr` (last served index).
  - `owner`, `lock`.
  - `cnt` (timeout counter).
  - `tx_byte`.
- States and transitions:
  - IDLE: the winner is the first requester with `req_valid`=1, searching `ptr+1, ptr+2, …` with wrap modulo N_REQ.
    - `req_ready[winner]`=1 is combinational, in the same cycle.
    - On the accept edge: `tx_byte`<=byte, `owner`<=winner, `ptr`<=winner, `lock`<=~`req_last[winner]`, go to START.
  - START: `transmit`=1 for exactly this cycle; `cnt`<=0; go to WAIT_START.
  - WAIT_START:
    - `is_transmitting`=1 → WAIT_DONE.
    - Otherwise `cnt`++. When `cnt`==TIMEOUT-1 with `is_transmitting` still 0 → pulse `timeout_err`, clear `lock`, go to IDLE.
  - WAIT_DONE: `is_transmitting`=0 → HOLD if `lock`, else IDLE.
  - HOLD:
    - `req_ready[owner]`=req_valid[owner]; every other ready is 0.
    - On accept, latch as in IDLE without changing `ptr` → START.
    - Other requesters wait indefinitely; there is no lock timeout.
- Outputs:
  - `grant` = one-hot(`owner`) in START, WAIT_START, WAIT_DONE and HOLD; 0 in IDLE.
  - `req_ready` is 0 in START, WAIT_START and WAIT_DONE.
- Fairness: a requester that has just finished an unlocked byte has the lowest priority on the next arbitration.
- `tx_byte` holds its value from acceptance until the next acceptance.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, `ptr`=N_REQ-1 (so requester 0 wins first), `owner`=0, `lock`=0, `cnt`=0.
  - `tx_byte`=8'h00, `transmit`=0, `grant`=0, `busy`=0, `timeout_err`=0.
  - `req_ready` is forced to 0 while rst=0.
- Reset mid-frame aborts sequencing immediately; the UART's own reset is handled at top level.
- Latency:
  - Accept at edge k, `transmit` high in cycle k+1.
  - Earliest next accept is one cycle after `is_transmitting` falls.
- Boundary conditions:
  - Simultaneous valid on all requesters: exactly one ready bit is high; the rest are held off.
  - `req_valid` dropping before ready: nothing is consumed.
  - `is_transmitting` already high in START is ignored; it is sampled only from WAIT_START onward.
  - `is_transmitting` high on the same cycle as the timeout terminal count: it counts as success and there is no error.
  - Locked requester that never revalidates: HOLD persists by design, `busy`=1.

## Test plan
- Single request: req 2 valid with byte 8'hA5, last=1.
  - Expect ready[2] the same cycle and `transmit` pulse the next cycle with `tx_byte`=8'hA5.
  - Expect grant=4'b0100 until UART idle, then busy=0.
- Contention: all four valid with last=1 continuously, from reset.
  - Expect serve order 0,1,2,3,0…, one byte per UART frame, and one received byte per frame at a looped-back second UART.
- Lock: req 1 sends 8'h10 (last=0) then 8'h11 (last=1) while req 0 stays valid.
  - Expect both req 1 bytes before req 0 is served, and grant held at 4'b0010 across the gap.
- Timeout: `is_transmitting` tied 0, TIMEOUT=16.
  - Expect `timeout_err` pulse exactly 16 cycles after the `transmit` pulse, then IDLE with the lock cleared, and the next requester accepted.
- Reset mid-frame: assert rst=0 during WAIT_DONE.
  - Expect all outputs at reset values asynchronously.
  - After release, req 3 alone is accepted normally and `ptr` restarts so requester 0 has priority.
- Back-to-back single requester: req 0 continuously valid, last=1.
  - Expect re-acceptance exactly one cycle after `is_transmitting` falls.
